// File: rtl/hp_glitch_seq.sv
// hp_glitch_seq: Wishbone-programmed sequencer that fires glitch shots at the
// wb_hp detector and tallies whether each shot was caught by its alarm latch.
module hp_glitch_seq #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned CHECK_CYC  = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  input  logic        hp_alarm_latch,
  output logic        hp_vcc,
  output logic        hp_alarm_rst,
  output logic        hp_alarm_ctr_rst,
  output logic        hp_glitch_en,
  output logic        glitch,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DELAY  = 3'd3,
    ST_PULSE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [2:0]  REG_CTRL    = 3'd0;
  localparam logic [2:0]  REG_DELAY   = 3'd1;
  localparam logic [2:0]  REG_WIDTH   = 3'd2;
  localparam logic [2:0]  REG_COUNT   = 3'd3;
  localparam logic [2:0]  REG_STATUS  = 3'd4;
  localparam logic [15:0] CLEAR_LAST  = 16'd1;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC) - 16'd1;
  localparam logic [15:0] CHECK_LAST  = 16'(CHECK_CYC) - 16'd1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_t      state_r, state_nx_s;
  logic [15:0] cnt_r, cnt_nx_s;
  logic [15:0] delay_r;
  logic [7:0]  width_r, count_r;
  logic [7:0]  shots_r, caught_r, missed_r;
  logic        done_r, hit_r;
  logic        ack_r;
  logic [31:0] rdata_r, rd_mux_s;
  logic        wb_req_s, wr_ctrl_s, start_s, abort_s, busy_s;
  logic        launch_s, shot_end_s, more_shots_s, hit_s;
  logic [15:0] pulse_last_s;
  logic        drive_nx_s, clear_nx_s, pulse_nx_s;
  logic [2:0]  reg_sel_s;
  logic        unused_bits_s;

  assign wb_req_s     = i_wb_cyc & i_wb_stb & (i_wb_addr[31:5] == BASE_ADDR[31:5]);
  assign reg_sel_s    = i_wb_addr[4:2];
  assign wr_ctrl_s    = wb_req_s & i_wb_we & (reg_sel_s == REG_CTRL);
  assign start_s      = wr_ctrl_s & i_wb_data[0] & ~i_wb_data[1];
  assign abort_s      = wr_ctrl_s & i_wb_data[1];
  assign busy_s       = (state_r != ST_IDLE);
  assign pulse_last_s = (width_r == 8'd0) ? 16'd0 : ({8'd0, width_r} - 16'd1);
  assign more_shots_s = ({1'b0, shots_r} + 9'd1) < {1'b0, count_r};
  assign hit_s        = hit_r | hp_alarm_latch;
  assign o_wb_ack     = ack_r;
  assign o_wb_data    = rdata_r;
  assign o_wb_stall   = 1'b0;
  assign unused_bits_s = ^{i_wb_addr[1:0], i_wb_data[31:16]};

  // Next-state and phase-counter logic; cnt_r holds remaining cycles minus one
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    launch_s   = 1'b0;
    shot_end_s = 1'b0;
    if (abort_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            launch_s = 1'b1;
            if (count_r == 8'd0) begin
              state_nx_s = ST_DONE;
            end else begin
              state_nx_s = ST_CLEAR;
              cnt_nx_s   = CLEAR_LAST;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (cnt_r != 16'd0) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else begin
            state_nx_s = ST_SETTLE;
            cnt_nx_s   = SETTLE_LAST;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != 16'd0) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else if (delay_r != 16'd0) begin
            state_nx_s = ST_DELAY;
            cnt_nx_s   = delay_r - 16'd1;
          end else begin
            state_nx_s = ST_PULSE;
            cnt_nx_s   = pulse_last_s;
          end
        end
        ST_DELAY: begin
          if (cnt_r != 16'd0) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else begin
            state_nx_s = ST_PULSE;
            cnt_nx_s   = pulse_last_s;
          end
        end
        ST_PULSE: begin
          if (cnt_r != 16'd0) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else begin
            state_nx_s = ST_CHECK;
            cnt_nx_s   = CHECK_LAST;
          end
        end
        ST_CHECK: begin
          if (cnt_r != 16'd0) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else begin
            shot_end_s = 1'b1;
            if (more_shots_s) begin
              state_nx_s = ST_CLEAR;
              cnt_nx_s   = CLEAR_LAST;
            end else begin
              state_nx_s = ST_DONE;
            end
          end
        end
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Drive pattern decoded from the next state so outputs register alongside it
  always_comb begin
    drive_nx_s = 1'b0;
    clear_nx_s = 1'b0;
    pulse_nx_s = 1'b0;
    case (state_nx_s)
      ST_CLEAR: begin
        drive_nx_s = 1'b1;
        clear_nx_s = 1'b1;
      end
      ST_SETTLE, ST_DELAY, ST_CHECK: drive_nx_s = 1'b1;
      ST_PULSE: begin
        drive_nx_s = 1'b1;
        pulse_nx_s = 1'b1;
      end
      default: begin
        drive_nx_s = 1'b0;
      end
    endcase
  end

  // State register and registered detector drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 16'd0;
      hp_vcc           <= 1'b0;
      hp_glitch_en     <= 1'b0;
      hp_alarm_rst     <= 1'b0;
      hp_alarm_ctr_rst <= 1'b0;
      glitch           <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state_r          <= state_nx_s;
      cnt_r            <= cnt_nx_s;
      hp_vcc           <= drive_nx_s;
      hp_glitch_en     <= drive_nx_s;
      hp_alarm_rst     <= clear_nx_s;
      hp_alarm_ctr_rst <= clear_nx_s;
      glitch           <= pulse_nx_s;
      busy             <= (state_nx_s != ST_IDLE);
    end
  end

  // Shot tallies and the per-shot sticky alarm flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shots_r  <= 8'd0;
      caught_r <= 8'd0;
      missed_r <= 8'd0;
      hit_r    <= 1'b0;
    end else if (launch_s) begin
      shots_r  <= 8'd0;
      caught_r <= 8'd0;
      missed_r <= 8'd0;
      hit_r    <= 1'b0;
    end else if (shot_end_s) begin
      shots_r <= shots_r + 8'd1;
      hit_r   <= 1'b0;
      if (hit_s) begin
        caught_r <= sat_inc(caught_r);
      end else begin
        missed_r <= sat_inc(missed_r);
      end
    end else if ((state_r == ST_CHECK) && hp_alarm_latch) begin
      hit_r <= 1'b1;
    end
  end

  // Done flag: set on DONE entry, cleared by a new launch or an abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r <= 1'b0;
    end else if (abort_s && busy_s) begin
      done_r <= 1'b0;
    end else if ((state_nx_s == ST_DONE) && (state_r != ST_DONE)) begin
      done_r <= 1'b1;
    end else if (launch_s) begin
      done_r <= 1'b0;
    end
  end

  // Campaign configuration, frozen while a campaign runs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delay_r <= 16'd0;
      width_r <= 8'd0;
      count_r <= 8'd0;
    end else if (wb_req_s && i_wb_we && !busy_s) begin
      case (reg_sel_s)
        REG_DELAY: delay_r <= i_wb_data[15:0];
        REG_WIDTH: width_r <= i_wb_data[7:0];
        REG_COUNT: count_r <= i_wb_data[7:0];
        default:   delay_r <= delay_r;
      endcase
    end
  end

  // Read-back mux
  always_comb begin
    rd_mux_s = 32'd0;
    case (reg_sel_s)
      REG_DELAY:  rd_mux_s = {16'd0, delay_r};
      REG_WIDTH:  rd_mux_s = {24'd0, width_r};
      REG_COUNT:  rd_mux_s = {24'd0, count_r};
      REG_STATUS: rd_mux_s = {missed_r, caught_r, shots_r, 3'd0, state_r, done_r, busy_s};
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Single-cycle ack with read data registered alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r   <= wb_req_s;
      rdata_r <= (wb_req_s && !i_wb_we) ? rd_mux_s : 32'd0;
    end
  end

endmodule
